// File: rtl/cpu_icache_pkg.sv
// Shared CPU package for the instruction cache: FSM state type and default geometry.
package cpu_icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_MISS_REQ = 3'd2,
    ST_REFILL   = 3'd3,
    ST_RESP     = 3'd4
  } icache_state_t;

  localparam int ICACHE_LINES          = 64;
  localparam int ICACHE_WORDS_PER_LINE = 4;
  localparam logic [31:0] BOOT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/cpu_icache_tag_array.sv
// Tag and valid storage for the direct-mapped I-cache; only the valid bits are reset.
module cpu_icache_tag_array #(
  parameter int LINES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_all,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_index,
  input  logic [TAG_W-1:0] set_tag,
  input  logic [IDX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];

  // Flush-all has priority over a same-cycle line set.
  always_ff @(posedge clock) begin
    if (reset || flush_all) begin
      valid <= '0;
    end else if (set_en) begin
      valid[set_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (set_en) begin
      tags[set_index] <= set_tag;
    end
  end

  assign hit = valid[lookup_index] && (tags[lookup_index] == lookup_tag);

endmodule

// File: rtl/cpu_icache.sv
// Direct-mapped read-only instruction cache with burst line refill.
// Optional ICACHE_PERF_EN adds saturating perf_hits / perf_misses counters.
module cpu_icache
  import cpu_icache_pkg::*;
#(
  parameter int LINES          = ICACHE_LINES,
  parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE,
  parameter int ADDR_W         = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_word,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses
`endif
);

  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - 2 - WORD_W - IDX_W;

  icache_state_t           state, state_next;
  logic [ADDR_W-1:2]       addr_p0;
  logic [WORD_W-1:0]       beat_cnt;
  logic                    flush_pending;
  logic                    flush_apply;
  logic                    last_beat;
  logic                    hit;
  logic [31:0]             rd_word;
  logic [31:0]             data_mem [LINES*WORDS_PER_LINE];
  logic                    unused_addr_bits;

  logic [WORD_W-1:0] req_word;
  logic [IDX_W-1:0]  req_index;
  logic [TAG_W-1:0]  req_tag;

  assign unused_addr_bits = ^req_addr[1:0];
  assign req_word  = addr_p0[2 +: WORD_W];
  assign req_index = addr_p0[2+WORD_W +: IDX_W];
  assign req_tag   = addr_p0[ADDR_W-1 -: TAG_W];
  assign rd_word   = data_mem[{req_index, req_word}];
  assign last_beat = (state == ST_REFILL) && mem_rsp_valid &&
                     (beat_cnt == WORD_W'(WORDS_PER_LINE - 1));

  // A flush seen while busy is deferred until the FSM returns to IDLE.
  assign flush_apply = (state == ST_IDLE) ? flush
                     : ((state_next == ST_IDLE) && (flush || flush_pending));

  cpu_icache_tag_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tags (
    .clock        (clock),
    .reset        (reset),
    .flush_all    (flush_apply),
    .set_en       (last_beat && !flush && !flush_pending),
    .set_index    (req_index),
    .set_tag      (req_tag),
    .lookup_index (req_index),
    .lookup_tag   (req_tag),
    .hit          (hit)
  );

  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_word      = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    case (state)
      ST_IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit) begin
          rsp_valid  = 1'b1;
          rsp_word   = rd_word;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_p0[ADDR_W-1:2+WORD_W], {(2+WORD_W){1'b0}}};
        if (mem_req_ready) state_next = ST_REFILL;
      end
      ST_REFILL: begin
        if (last_beat) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        rsp_word   = rd_word;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      beat_cnt      <= '0;
      flush_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_REFILL && mem_rsp_valid) beat_cnt <= beat_cnt + 1'b1;
      if (flush_apply) begin
        flush_pending <= 1'b0;
      end else if (flush && state != ST_IDLE) begin
        flush_pending <= 1'b1;
      end
    end
  end

  // Request address and line data are not reset.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && req_valid && req_ready) addr_p0 <= req_addr[ADDR_W-1:2];
    if (state == ST_REFILL && mem_rsp_valid) data_mem[{req_index, beat_cnt}] <= mem_rsp_data;
  end

`ifdef ICACHE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (state == ST_LOOKUP) begin
      if (hit) perf_hits   <= sat_inc(perf_hits);
      else     perf_misses <= sat_inc(perf_misses);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_icache.sv
// Scoreboard bench for cpu_icache: directed scenarios followed by randomized traffic.
module tb_cpu_icache;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_word;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;
`endif

  cpu_icache dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_word      (rsp_word),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hits     (perf_hits),
    .perf_misses   (perf_misses)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  // Reference model: backing memory plus a per-index valid/tag view of the cache.
  logic [31:0] mem_model [logic [31:0]];
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  int          m_hits = 0;
  int          m_misses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic get_word(input logic [31:0] a, output logic [31:0] w);
    if (!mem_model.exists(a)) mem_model[a] = $urandom;
    w = mem_model[a];
  endtask

  task automatic model_invalidate();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got rsp_word %h with no request outstanding", rsp_word);
      end else begin
        check("rsp_word", rsp_word, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // mode 0: plain request, 1: flush pulse during refill, 2: reset after two refill beats
  task automatic do_req(input logic [31:0] addr, input int mode, input int rdy_delay);
    int          idx;
    logic [21:0] tag;
    logic [31:0] line, w;
    bit          hit;
    idx  = int'((addr >> 4) & 32'h3F);
    tag  = addr[31:10];
    line = addr & ~32'hF;
    hit  = m_valid[idx] && (m_tag[idx] == tag);
    get_word(addr & ~32'h3, w);
    if (hit || mode != 2) exp_q.push_back(w);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    req_addr  = $urandom;
    #1;
    check("lookup_req_ready", {31'd0, req_ready}, 32'd0);
    check("lookup_hit", {31'd0, rsp_valid}, {31'd0, hit});
    check("lookup_mem_req", {31'd0, mem_req_valid}, 32'd0);
    if (hit) begin
      m_hits++;
      step();
      return;
    end
    m_misses++;
    step();
    for (int c = 0; c < rdy_delay; c++) begin
      check("mem_req_valid_held", {31'd0, mem_req_valid}, 32'd1);
      check("mem_req_addr_held", mem_req_addr, line);
      check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      step();
    end
    mem_req_ready = 1'b1;
    #1;
    check("mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("mem_req_addr", mem_req_addr, line);
    step();
    mem_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(0, 2)) step();
      if (mode == 2 && b == 2) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        model_invalidate();
        m_hits = 0;
        m_misses = 0;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        return;
      end
      get_word(line + 32'(4 * b), w);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = w;
      if (mode == 1 && b == 1) flush = 1'b1;
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
      flush = 1'b0;
    end
    #1;
    check("resp_after_last_beat", {31'd0, rsp_valid}, 32'd1);
    if (mode == 1) begin
      model_invalidate();
    end else begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    step();
  endtask

  // Idle cycles with stray refill beats that the cache must ignore.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rsp_data  = $urandom;
      step();
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic flush_idle(input bit with_req);
    flush     = 1'b1;
    req_valid = with_req;
    req_addr  = $urandom;
    #1;
    check("flush_req_ready", {31'd0, req_ready}, 32'd0);
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    model_invalidate();
  endtask

  task automatic check_perf();
`ifdef ICACHE_PERF_EN
    check("perf_hits", perf_hits, 32'(m_hits));
    check("perf_misses", perf_misses, 32'(m_misses));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pool [6];
    logic [31:0] a;
    int          r;
    pool = '{32'h000, 32'h100, 32'h140, 32'h500, 32'h900, 32'h1100};
    mem_model[32'h100] = 32'hA0;
    mem_model[32'h104] = 32'hA1;
    mem_model[32'h108] = 32'hA2;
    mem_model[32'h10C] = 32'hA3;
    model_invalidate();

    repeat (3) step();
    reset = 1'b0;
    #1;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("reset_rsp_word", rsp_word, 32'd0);
    check("reset_mem_req_addr", mem_req_addr, 32'd0);
    check_perf();

    do_req(32'h104, 0, 0);
    do_req(32'h10C, 0, 0);
    do_req(32'h500, 0, 1);
    check_perf();
    do_req(32'h104, 0, 0);
    idle(3);
    flush_idle(1'b0);
    do_req(32'h104, 0, 0);
    flush_idle(1'b1);
    do_req(32'h108, 0, 0);
    do_req(32'h200, 1, 0);
    do_req(32'h204, 0, 0);
    do_req(32'h3F8, 0, 3);
    do_req(32'h3F4, 0, 0);
    do_req(32'h700, 2, 0);
    do_req(32'h3F4, 0, 0);
    check_perf();

    for (int n = 0; n < 150; n++) begin
      a = pool[$urandom_range(0, 5)] + 32'($urandom_range(0, 15));
      r = $urandom_range(0, 19);
      if (r == 0) flush_idle(1'($urandom_range(0, 1)));
      if (r == 1)      do_req(a, 1, $urandom_range(0, 3));
      else if (r == 2) do_req(a, 2, $urandom_range(0, 3));
      else             do_req(a, 0, $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end
    check_perf();
    idle(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
